id_ex_hazard_stage: RTL and testbench
=====================================

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, extra EX hold cycles after a mul (ALUOp 4'b0010) enters EX; legal range 1..7.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port CtrlD  input  12  decoded controls from the main controller, packed {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemRead,MemToReg,zeroExt,ALUOp[3:0]}.
REQ-005 SHALL have ports RsD, RtD, RdD  input  5 each  register fields of the ID instruction.
REQ-006 SHALL have ports RD1D, RD2D, ImmD, PCPlus4D  input  32 each  register-file reads, extended immediate, PC+4 in ID.
REQ-007 SHALL have port FlushE  input  1  taken branch resolved downstream; squash the instruction in ID.
REQ-008 SHALL have port CtrlE  output  12  registered controls for EX, same packing as CtrlD.
REQ-009 SHALL have ports RsE, RtE, RdE (5 each) and RD1E, RD2E, ImmE, PCPlus4E (32 each)  output  registered ID/EX datapath fields.
REQ-010 SHALL have ports PCWrite, IFIDWrite  output  1 each  enables for PC and IF/ID registers; low = freeze.
REQ-011 SHALL have port StallD  output  1  high whenever ID is held this cycle.

Function
REQ-012 Bubble SHALL mean CtrlE = 12'b0 (no RegWrite, MemWrite, MemRead, Branch); datapath fields of a bubble are don't-care but SHALL be zeroed.
REQ-013 Load-use hazard (LU) SHALL be combinational: CtrlE.MemRead & RtE!=0 & (RtE==RsD | RtE==RtD).
REQ-014 FSM states SHALL be RUN, MULBUSY; a 3-bit counter MulCnt tracks MULBUSY cycles remaining.
REQ-015 In RUN, priority per edge SHALL be FlushE > LU > normal advance.
REQ-016 RUN, FlushE=1: ID/EX loads bubble, stay RUN; PCWrite=IFIDWrite=1, StallD=0 (fetch redirect owned upstream).
REQ-017 RUN, LU=1, FlushE=0: ID/EX loads bubble; PCWrite=IFIDWrite=0, StallD=1; one-cycle stall only, since the bubble clears LU next cycle.
REQ-018 RUN, no flush/LU: ID/EX loads all D inputs; if CtrlD.ALUOp==4'b0010 and CtrlD.RegWrite, next state MULBUSY, MulCnt=MUL_LAT.
REQ-019 MULBUSY: ID/EX holds contents, PCWrite=IFIDWrite=0, StallD=1; MulCnt decrements each edge; at MulCnt==1 next state RUN.
REQ-020 MULBUSY with FlushE=1 SHALL NOT abort the mul in EX (it is older than the branch); flush SHALL be remembered in a FlushPend flag and applied as a bubble on the first RUN edge.
REQ-021 Combinational outputs PCWrite, IFIDWrite, StallD SHALL depend only on state, CtrlE, RtE, RsD, RtD, FlushE (no D-datapath inputs).
REQ-022 Back-to-back muls SHALL each incur full MUL_LAT hold; a load followed by a dependent mul SHALL take the LU stall first, then MULBUSY.
REQ-023 rt==$0 dependencies SHALL never stall.

Reset
REQ-024 Rst=1 at an edge SHALL force state RUN, MulCnt=0, FlushPend=0, all E outputs 0 (i.e. a bubble), overriding every other input including mid-MULBUSY.
REQ-025 While Rst=1: PCWrite=IFIDWrite=1, StallD=0.

Structure
REQ-026 Shared package SHALL hold CtrlE field bit positions, ALUOP_MUL=4'b0010, the FSM state encoding and the bubble constant.
REQ-027 One sub-module, hazard_detect (combinational LU compare), is natural; the pipeline register and FSM stay in the top.

Verification
REQ-028 lw $t0 in EX (MemRead=1, RtE=8), ID add uses RsD=8 -> StallD=1 one cycle, next CtrlE=0, then the add enters EX with RsE=8.
REQ-029 Same as 028 with RtE=0 -> no stall, add advances immediately.
REQ-030 mul (ALUOp 0010) in ID, MUL_LAT=2 -> enters EX, then 2 cycles with PCWrite=0 and CtrlE unchanged, then next instr enters.
REQ-031 FlushE=1 while beq in ID, no hazard -> next CtrlE=0, PCWrite=1.
REQ-032 FlushE=1 during cycle 1 of MULBUSY -> mul held full 2 cycles, then one bubble, then normal advance.
REQ-033 Rst asserted mid-MULBUSY -> next edge CtrlE=0, state RUN, PCWrite=1, StallD=0.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// rtl/id_ex_hazard_stage_pkg.sv - shared control packing, FSM encoding and constants for the ID/EX stage
package id_ex_hazard_stage_pkg;

  localparam int CTRL_W = 12;

  // Bit positions inside the packed control word (CtrlD / CtrlE)
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_REGDST   = 10;
  localparam int CTRL_ALUSRC   = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ZEROEXT  = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [3:0]        ALUOP_MUL   = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MULBUSY = 1'b1
  } state_t;

  // A mul only needs the multi-cycle hold when it actually writes a result
  function automatic logic is_mul_write(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] && (ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] == ALUOP_MUL);
  endfunction

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// rtl/id_ex_hazard_stage_hazard_detect.sv - combinational load-use compare between EX load and ID sources
module hazard_detect (
  input  logic       memread_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  output logic       lu
);

  // $0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = memread_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use stall, multi-cycle mul hold and flush
module id_ex_hazard_stage
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmD,
  input  logic [31:0]       PCPlus4D,
  input  logic              FlushE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmE,
  output logic [31:0]       PCPlus4E,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              StallD
);

  localparam logic [2:0] MUL_LAT_CNT = 3'(MUL_LAT);

  state_t     state;
  logic [2:0] mul_cnt;
  logic       flush_pend;
  logic       lu;
  logic       hold_d;

  hazard_detect u_hazard_detect (
    .memread_e (CtrlE[CTRL_MEMREAD]),
    .rt_e      (RtE),
    .rs_d      (RsD),
    .rt_d      (RtD),
    .lu        (lu)
  );

  // A pending flush outranks load-use exactly like a live FlushE
  always_comb begin
    hold_d = 1'b0;
    if (Rst) begin
      hold_d = 1'b0;
    end else if (state == ST_MULBUSY) begin
      hold_d = 1'b1;
    end else if (!(FlushE || flush_pend)) begin
      hold_d = lu;
    end
  end

  assign PCWrite   = !hold_d;
  assign IFIDWrite = !hold_d;
  assign StallD    = hold_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_RUN;
      mul_cnt    <= 3'd0;
      flush_pend <= 1'b0;
      CtrlE      <= CTRL_BUBBLE;
      RsE        <= '0;
      RtE        <= '0;
      RdE        <= '0;
      RD1E       <= '0;
      RD2E       <= '0;
      ImmE       <= '0;
      PCPlus4E   <= '0;
    end else if (state == ST_MULBUSY) begin
      // The mul in EX is older than any branch, so a flush only gets remembered here
      mul_cnt    <= mul_cnt - 3'd1;
      flush_pend <= flush_pend || FlushE;
      if (mul_cnt == 3'd1) begin
        state <= ST_RUN;
      end
    end else begin
      if (FlushE || flush_pend || lu) begin
        flush_pend <= 1'b0;
        CtrlE      <= CTRL_BUBBLE;
        RsE        <= '0;
        RtE        <= '0;
        RdE        <= '0;
        RD1E       <= '0;
        RD2E       <= '0;
        ImmE       <= '0;
        PCPlus4E   <= '0;
      end else begin
        CtrlE    <= CtrlD;
        RsE      <= RsD;
        RtE      <= RtD;
        RdE      <= RdD;
        RD1E     <= RD1D;
        RD2E     <= RD2D;
        ImmE     <= ImmD;
        PCPlus4E <= PCPlus4D;
        if (is_mul_write(CtrlD)) begin
          state   <= ST_MULBUSY;
          mul_cnt <= MUL_LAT_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb/tb_id_ex_hazard_stage.sv - randomized bench with behavioural reference model for id_ex_hazard_stage
module tb_id_ex_hazard_stage;

  localparam int MUL_LAT = 2;

  localparam logic [11:0] C_LW  = 12'hA60;
  localparam logic [11:0] C_ADD = 12'hC01;
  localparam logic [11:0] C_MUL = 12'hC02;
  localparam logic [11:0] C_BEQ = 12'h106;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  logic        Clk;
  logic        Rst;
  logic [11:0] CtrlD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] RD1D, RD2D, ImmD, PCPlus4D;
  logic        FlushE;
  logic [11:0] CtrlE;
  logic [4:0]  RsE, RtE, RdE;
  logic [31:0] RD1E, RD2E, ImmE, PCPlus4E;
  logic        PCWrite, IFIDWrite, StallD;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: what sits in EX, how many more cycles it must stay, and whether a flush is owed
  ex_t m_e        = '0;
  int  m_hold     = 0;
  bit  m_pend     = 1'b0;

  id_ex_hazard_stage #(.MUL_LAT(MUL_LAT)) dut (
    .Clk(Clk), .Rst(Rst), .CtrlD(CtrlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .PCPlus4D(PCPlus4D), .FlushE(FlushE),
    .CtrlE(CtrlE), .RsE(RsE), .RtE(RtE), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmE(ImmE), .PCPlus4E(PCPlus4E), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .StallD(StallD)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return m_e.ctrl[6] && (m_e.rt != 5'd0) && ((m_e.rt == RsD) || (m_e.rt == RtD));
  endfunction

  function automatic bit model_advance();
    if (Rst) return 1'b1;
    if (m_hold > 0) return 1'b0;
    if (FlushE || m_pend) return 1'b1;
    return !model_lu();
  endfunction

  task automatic model_step();
    ex_t d;
    d = '{ctrl: CtrlD, rs: RsD, rt: RtD, rd: RdD, rd1: RD1D, rd2: RD2D, imm: ImmD, pc: PCPlus4D};
    if (Rst) begin
      m_e = '0; m_hold = 0; m_pend = 1'b0;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      m_pend = m_pend || FlushE;
    end else if (FlushE || m_pend || model_lu()) begin
      m_e = '0; m_pend = 1'b0;
    end else begin
      m_e = d;
      if (CtrlD[11] && CtrlD[3:0] == 4'b0010) m_hold = MUL_LAT;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic set_d(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    CtrlD = c; RsD = rs; RtD = rt; RdD = rd;
    RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; PCPlus4D = $urandom;
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("CtrlE", 32'(CtrlE), 32'(m_e.ctrl));
      chk("RsE", 32'(RsE), 32'(m_e.rs));
      chk("RtE", 32'(RtE), 32'(m_e.rt));
      chk("RdE", 32'(RdE), 32'(m_e.rd));
      chk("RD1E", RD1E, m_e.rd1);
      chk("RD2E", RD2E, m_e.rd2);
      chk("ImmE", ImmE, m_e.imm);
      chk("PCPlus4E", PCPlus4E, m_e.pc);
      chk("PCWrite", 32'(PCWrite), 32'(model_advance()));
      chk("IFIDWrite", 32'(IFIDWrite), 32'(model_advance()));
      chk("StallD", 32'(StallD), 32'(!model_advance()));
    end
  end

  initial begin
    Rst = 1'b1; FlushE = 1'b0;
    set_d(12'h000, 5'd0, 5'd0, 5'd0);
    #1 chk("rst_pcwrite", 32'(PCWrite), 32'd1);
    chk("rst_stalld", 32'(StallD), 32'd0);
    tick();
    cmp_en = 1'b1;
    chk("rst_ctrle", 32'(CtrlE), 32'd0);
    chk("rst_pc4e", PCPlus4E, 32'd0);
    Rst = 1'b0;

    // lw $t0 then dependent add
    set_d(C_LW, 5'd1, 5'd8, 5'd0); tick();
    set_d(C_ADD, 5'd8, 5'd9, 5'd10);
    #1 chk("lu_stall", 32'(StallD), 32'd1);
    chk("lu_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    chk("lu_bubble", 32'(CtrlE), 32'd0);
    chk("lu_released", 32'(StallD), 32'd0);
    tick();
    chk("lu_add_ctrl", 32'(CtrlE), 32'(C_ADD));
    chk("lu_add_rs", 32'(RsE), 32'd8);

    // load into $0 never stalls
    set_d(C_LW, 5'd1, 5'd0, 5'd0); tick();
    set_d(C_ADD, 5'd0, 5'd9, 5'd10);
    #1 chk("rt0_nostall", 32'(StallD), 32'd0);
    tick();
    chk("rt0_add", 32'(CtrlE), 32'(C_ADD));

    // mul holds EX for MUL_LAT extra cycles
    set_d(C_MUL, 5'd2, 5'd3, 5'd4); tick();
    set_d(C_ADD, 5'd5, 5'd6, 5'd7);
    #1 chk("mul_c0_pcw", 32'(PCWrite), 32'd0);
    chk("mul_c0_ctrl", 32'(CtrlE), 32'(C_MUL));
    tick();
    chk("mul_c1_pcw", 32'(PCWrite), 32'd0);
    chk("mul_c1_ctrl", 32'(CtrlE), 32'(C_MUL));
    tick();
    chk("mul_c2_pcw", 32'(PCWrite), 32'd1);
    chk("mul_c2_ctrl", 32'(CtrlE), 32'(C_MUL));
    tick();
    chk("mul_next", 32'(CtrlE), 32'(C_ADD));
    chk("mul_next_rs", 32'(RsE), 32'd5);

    // flush of beq in ID
    set_d(C_BEQ, 5'd1, 5'd2, 5'd0); FlushE = 1'b1;
    #1 chk("fl_pcwrite", 32'(PCWrite), 32'd1);
    chk("fl_stalld", 32'(StallD), 32'd0);
    tick(); FlushE = 1'b0;
    chk("fl_bubble", 32'(CtrlE), 32'd0);

    // flush during MULBUSY is deferred
    set_d(C_MUL, 5'd2, 5'd3, 5'd4); tick();
    FlushE = 1'b1; set_d(C_ADD, 5'd11, 5'd12, 5'd13); tick();
    FlushE = 1'b0;
    chk("mfl_c1_ctrl", 32'(CtrlE), 32'(C_MUL));
    chk("mfl_c1_stall", 32'(StallD), 32'd1);
    tick();
    chk("mfl_c2_ctrl", 32'(CtrlE), 32'(C_MUL));
    chk("mfl_c2_stall", 32'(StallD), 32'd0);
    tick();
    chk("mfl_bubble", 32'(CtrlE), 32'd0);
    tick();
    chk("mfl_advance", 32'(CtrlE), 32'(C_ADD));
    chk("mfl_advance_rs", 32'(RsE), 32'd11);

    // reset mid-MULBUSY
    set_d(C_MUL, 5'd2, 5'd3, 5'd4); tick();
    Rst = 1'b1;
    #1 chk("mrst_pcw", 32'(PCWrite), 32'd1);
    chk("mrst_stall", 32'(StallD), 32'd0);
    tick(); Rst = 1'b0;
    #1 chk("mrst_ctrl", 32'(CtrlE), 32'd0);
    chk("mrst_pcw_after", 32'(PCWrite), 32'd1);
    chk("mrst_stall_after", 32'(StallD), 32'd0);

    // randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      logic [11:0] c;
      c = 12'($urandom);
      if ($urandom_range(0, 3) == 0) c[3:0] = 4'b0010;
      c[6] = ($urandom_range(0, 1) == 1);
      set_d(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      FlushE = ($urandom_range(0, 9) == 0);
      Rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    Rst = 1'b0; FlushE = 1'b0;
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
